alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares the single execute-stage ALU between two requesters: Req0, the pipeline execute stage, and Req1, an auxiliary requester such as address generation or a CSR/microcode sequencer. The block arbitrates round-robin and registers the winning operation into an issue stage that drives the ALU. It then captures the ALU result into a response stage and returns it to the owning requester under valid/ready handshakes. Throughput is one operation per cycle; fixed latency is 2 cycles from acceptance to response.

Parameters:
XLEN, 64, operand/result width
CW, 4, ALUControl width (ALU op encoding passed through unmodified)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
Flush  in  1  synchronous pipeline flush; drops all in-flight operations
Req0Valid  in  1  requester 0 has an operation
Req0Ready  out  1  requester 0 operation accepted this cycle
Req0SrcA  in  XLEN  requester 0 operand A
Req0SrcB  in  XLEN  requester 0 operand B
Req0ALUControl  in  CW  requester 0 ALU op
Req1Valid, Req1Ready, Req1SrcA, Req1SrcB, Req1ALUControl  as above, requester 1
Rsp0Valid  out  1  response for requester 0 available
Rsp0Ready  in  1  requester 0 consumes response
Rsp1Valid  out  1  response for requester 1 available
Rsp1Ready  in  1  requester 1 consumes response
RspResult  out  XLEN  registered ALU result (shared by both responses)
RspZero  out  1  registered ALU Zero flag
AluSrcA  out  XLEN  to ALU SrcA
AluSrcB  out  XLEN  to ALU SrcB
AluControl  out  CW  to ALU ALUControl
AluResult  in  XLEN  from ALU
AluZero  in  1  from ALU
Busy  out  1  issue or response stage valid

Behaviour:
- Reset (async, any time, including mid-operation): IssValid=0, RspValid=0, RspResult=0, RspZero=0, issue operand/ctl regs=0, LastGrant=1 so Req0 wins first. Resulting outputs: ReqNReady=0, RspNValid=0, AluSrcA/B=0, AluControl=0, Busy=0. In-flight operations are lost; no response is produced for them.
- Issue stage: registers IssValid, IssId, IssA, IssB, IssCtl. AluSrcA/AluSrcB/AluControl come straight from these registers. When IssValid=0 they are forced to 0.
- Response stage: registers RspValid, RspId, RspResult, RspZero.
  - Rsp0Valid = RspValid & (RspId==0); Rsp1Valid = RspValid & (RspId==1).
  - RspDrain = RspValid & Rsp[RspId]Ready.
- Advance: IssAdv = IssValid & (!RspValid | RspDrain).
  - On IssAdv the response stage loads {IssId, AluResult, AluZero}.
  - Otherwise, on RspDrain, RspValid clears.
  - Otherwise the response stage holds.
- Accept: CanAccept = !Flush & (!IssValid | IssAdv).
- Grant (combinational):
  - One requester valid: it wins.
  - Both valid: the requester != LastGrant wins.
  - ReqNReady = CanAccept & winner==N. At most one Ready is high per cycle.
- On acceptance: the issue stage loads the winner's operands/op and IssId; LastGrant := winner.
  - If IssAdv and no acceptance: IssValid clears.
  - A stalled issue stage holds all fields.
- Latency: accepted in cycle k → ALU driven in cycle k+1 → RspNValid=1 in cycle k+2 if not back-pressured.
- Back-pressure: a response held with Ready=0 stalls the issue stage. Once the issue stage is also full, both ReqNReady=0. No operation is dropped or reordered.
- Requesters hold operands/op stable while Valid & !Ready. The arbiter does not register the grant before acceptance, so a requester withdrawing Valid is legal and simply loses the grant.
- Flush (synchronous): next edge clears IssValid and RspValid; no acceptance that cycle. Data regs may retain values. Flush takes priority over accept, advance and drain.
- Busy = IssValid | RspValid.
- The ALU op is opaque to this block: no decode, all CW codes are forwarded.

Test Plan:
- Single op: Req0 ADD (ctl 0000), A=5, B=7, valid cycle 0 → Req0Ready=1 in cycle 0; cycle 1 AluSrcA=5, AluSrcB=7; cycle 2 Rsp0Valid=1, RspResult=12, RspZero=0, Rsp1Valid=0.
- Contention: both valid in cycles 0–1; Req0 SUB (0001) 3−3, Req1 sh2add (0101) A=2, B=1 → grant Req0 in cycle 0, Req1 in cycle 1; cycle 2 Rsp0: result 0, Zero=1; cycle 3 Rsp1: result 9.
- Fairness: both held valid with streams for 8 cycles, all Ready=1 → grants strictly alternate 0,1,0,1…; 4 responses each, in order.
- Back-pressure: Req0 ADD 1+1, Rsp0Ready=0 for 3 cycles → Rsp0Valid/RspResult=2 held stable. A second op accepted into the issue stage, after which Req0Ready=Req1Ready=0. On Ready=1, drains in order with no loss.
- Flush: op accepted in cycle 0, Flush=1 in cycle 1 → no RspNValid ever for that op; Busy=0 in cycle 2; a new op requested in cycle 2 completes normally in cycle 4.
- Async reset mid-op: assert reset between edges while IssValid=1 and RspValid=1 → all outputs 0 immediately. After release, simultaneous requests grant Req0 first.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Bundle of requester, response and ALU-side signals for the shared-ALU arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the ALU.
interface alu_arbiter_if #(
    parameter int XLEN = 64,
    parameter int CW   = 4
);
    logic            Flush;

    logic            Req0Valid;
    logic            Req0Ready;
    logic [XLEN-1:0] Req0SrcA;
    logic [XLEN-1:0] Req0SrcB;
    logic [CW-1:0]   Req0ALUControl;

    logic            Req1Valid;
    logic            Req1Ready;
    logic [XLEN-1:0] Req1SrcA;
    logic [XLEN-1:0] Req1SrcB;
    logic [CW-1:0]   Req1ALUControl;

    logic            Rsp0Valid;
    logic            Rsp0Ready;
    logic            Rsp1Valid;
    logic            Rsp1Ready;
    logic [XLEN-1:0] RspResult;
    logic            RspZero;

    logic [XLEN-1:0] AluSrcA;
    logic [XLEN-1:0] AluSrcB;
    logic [CW-1:0]   AluControl;
    logic [XLEN-1:0] AluResult;
    logic            AluZero;

    logic            Busy;

    modport slave (
        input  Flush,
        input  Req0Valid, Req0SrcA, Req0SrcB, Req0ALUControl,
        output Req0Ready,
        input  Req1Valid, Req1SrcA, Req1SrcB, Req1ALUControl,
        output Req1Ready,
        output Rsp0Valid, Rsp1Valid, RspResult, RspZero,
        input  Rsp0Ready, Rsp1Ready,
        output AluSrcA, AluSrcB, AluControl,
        input  AluResult, AluZero,
        output Busy
    );

    modport master (
        output Flush,
        output Req0Valid, Req0SrcA, Req0SrcB, Req0ALUControl,
        input  Req0Ready,
        output Req1Valid, Req1SrcA, Req1SrcB, Req1ALUControl,
        input  Req1Ready,
        input  Rsp0Valid, Rsp1Valid, RspResult, RspZero,
        output Rsp0Ready, Rsp1Ready,
        input  AluSrcA, AluSrcB, AluControl,
        output AluResult, AluZero,
        input  Busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters through an issue stage
// and a response stage; fixed two-cycle latency, one operation per cycle.
module alu_arbiter #(
    parameter int XLEN = 64,
    parameter int CW   = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    alu_arbiter_if.slave  bus
);
    logic            r_iss_valid;
    logic            r_iss_id;
    logic [XLEN-1:0] r_iss_a;
    logic [XLEN-1:0] r_iss_b;
    logic [CW-1:0]   r_iss_ctl;

    logic            r_rsp_valid;
    logic            r_rsp_id;
    logic [XLEN-1:0] r_rsp_result;
    logic            r_rsp_zero;

    logic            r_last_grant;

    logic            w_rsp_drain;
    logic            w_iss_adv;
    logic            w_can_accept;
    logic            w_winner;
    logic            w_accept;

    assign w_rsp_drain  = r_rsp_valid & (r_rsp_id ? bus.Rsp1Ready : bus.Rsp0Ready);
    assign w_iss_adv    = r_iss_valid & (~r_rsp_valid | w_rsp_drain);
    // Holding Ready low while reset is asserted keeps every output quiet during reset.
    assign w_can_accept = ~i_rst & ~bus.Flush & (~r_iss_valid | w_iss_adv);

    always_comb begin
        w_winner = 1'b0;
        if (bus.Req0Valid && bus.Req1Valid) begin
            w_winner = ~r_last_grant;
        end else if (bus.Req1Valid) begin
            w_winner = 1'b1;
        end
    end

    assign w_accept      = w_can_accept & (bus.Req0Valid | bus.Req1Valid);
    assign bus.Req0Ready = w_can_accept & bus.Req0Valid & ~w_winner;
    assign bus.Req1Ready = w_can_accept & bus.Req1Valid & w_winner;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_iss_valid  <= 1'b0;
            r_iss_id     <= 1'b0;
            r_iss_a      <= '0;
            r_iss_b      <= '0;
            r_iss_ctl    <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (bus.Flush) begin
            r_iss_valid <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            if (w_iss_adv) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_id     <= r_iss_id;
                r_rsp_result <= bus.AluResult;
                r_rsp_zero   <= bus.AluZero;
            end else if (w_rsp_drain) begin
                r_rsp_valid <= 1'b0;
            end

            if (w_accept) begin
                r_iss_valid  <= 1'b1;
                r_iss_id     <= w_winner;
                r_iss_a      <= w_winner ? bus.Req1SrcA : bus.Req0SrcA;
                r_iss_b      <= w_winner ? bus.Req1SrcB : bus.Req0SrcB;
                r_iss_ctl    <= w_winner ? bus.Req1ALUControl : bus.Req0ALUControl;
                r_last_grant <= w_winner;
            end else if (w_iss_adv) begin
                r_iss_valid <= 1'b0;
            end
        end
    end

    assign bus.AluSrcA    = r_iss_valid ? r_iss_a   : '0;
    assign bus.AluSrcB    = r_iss_valid ? r_iss_b   : '0;
    assign bus.AluControl = r_iss_valid ? r_iss_ctl : '0;

    assign bus.Rsp0Valid = r_rsp_valid & ~r_rsp_id;
    assign bus.Rsp1Valid = r_rsp_valid & r_rsp_id;
    assign bus.RspResult = r_rsp_result;
    assign bus.RspZero   = r_rsp_zero;
    assign bus.Busy      = r_iss_valid | r_rsp_valid;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: contention, fairness, back-pressure, flush and
// async reset, with a small behavioural ALU closing the loop.
module tb_alu_arbiter;
    localparam int XLEN = 64;
    localparam int CW   = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;
    int   n0, n1, id;

    alu_arbiter_if #(.XLEN(XLEN), .CW(CW)) bus ();

    alu_arbiter #(.XLEN(XLEN), .CW(CW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Stand-in ALU: add, sub, sh2add, anything else AND.
    always_comb begin
        logic [XLEN-1:0] res;
        res = '0;
        case (bus.AluControl)
            4'b0000: res = bus.AluSrcA + bus.AluSrcB;
            4'b0001: res = bus.AluSrcA - bus.AluSrcB;
            4'b0101: res = (bus.AluSrcA << 2) + bus.AluSrcB;
            default: res = bus.AluSrcA & bus.AluSrcB;
        endcase
        bus.AluResult = res;
        bus.AluZero   = (res == '0);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.Flush          = 1'b0;
        bus.Req0Valid      = 1'b0;
        bus.Req0SrcA       = '0;
        bus.Req0SrcB       = '0;
        bus.Req0ALUControl = '0;
        bus.Req1Valid      = 1'b0;
        bus.Req1SrcA       = '0;
        bus.Req1SrcB       = '0;
        bus.Req1ALUControl = '0;
        bus.Rsp0Ready      = 1'b1;
        bus.Rsp1Ready      = 1'b1;
    endtask

    task automatic req0(input logic [63:0] a, input logic [63:0] b, input logic [3:0] c);
        bus.Req0Valid      = 1'b1;
        bus.Req0SrcA       = a;
        bus.Req0SrcB       = b;
        bus.Req0ALUControl = c;
    endtask

    task automatic req1(input logic [63:0] a, input logic [63:0] b, input logic [3:0] c);
        bus.Req1Valid      = 1'b1;
        bus.Req1SrcA       = a;
        bus.Req1SrcB       = b;
        bus.Req1ALUControl = c;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        next_cycle();
        next_cycle();
        #1;
        chk("rst_busy", bus.Busy, 0);
        chk("rst_rdy0", bus.Req0Ready, 0);
        chk("rst_rsp0v", bus.Rsp0Valid, 0);
        chk("rst_result", bus.RspResult, 0);
        chk("rst_alua", bus.AluSrcA, 0);
        rst = 1'b0;
        next_cycle();

        // contention: Req0 SUB 3-3 wins first, Req1 sh2add 2,1 next
        req0(3, 3, 4'b0001);
        req1(2, 1, 4'b0101);
        #1;
        chk("cont_c0_rdy0", bus.Req0Ready, 1);
        chk("cont_c0_rdy1", bus.Req1Ready, 0);
        next_cycle();
        #1;
        chk("cont_c1_rdy0", bus.Req0Ready, 0);
        chk("cont_c1_rdy1", bus.Req1Ready, 1);
        chk("cont_c1_alua", bus.AluSrcA, 3);
        chk("cont_c1_ctl", bus.AluControl, 1);
        next_cycle();
        idle();
        #1;
        chk("cont_c2_rsp0v", bus.Rsp0Valid, 1);
        chk("cont_c2_rsp1v", bus.Rsp1Valid, 0);
        chk("cont_c2_res", bus.RspResult, 0);
        chk("cont_c2_zero", bus.RspZero, 1);
        chk("cont_c2_ctl", bus.AluControl, 5);
        next_cycle();
        #1;
        chk("cont_c3_rsp1v", bus.Rsp1Valid, 1);
        chk("cont_c3_rsp0v", bus.Rsp0Valid, 0);
        chk("cont_c3_res", bus.RspResult, 9);
        chk("cont_c3_zero", bus.RspZero, 0);
        next_cycle();
        #1;
        chk("cont_c4_busy", bus.Busy, 0);

        // fairness: both streams held valid for 8 cycles
        n0 = 0;
        n1 = 0;
        for (int c = 0; c < 10; c++) begin
            bus.Req0Valid      = (c < 8);
            bus.Req0SrcA       = 64'(n0);
            bus.Req0SrcB       = 100;
            bus.Req0ALUControl = 4'b0000;
            bus.Req1Valid      = (c < 8);
            bus.Req1SrcA       = 64'(n1);
            bus.Req1SrcB       = 200;
            bus.Req1ALUControl = 4'b0000;
            #1;
            if (c < 8) begin
                chk("fair_rdy0", bus.Req0Ready, 64'(c % 2 == 0));
                chk("fair_rdy1", bus.Req1Ready, 64'(c % 2 == 1));
            end
            if (c >= 2) begin
                id = (c - 2) % 2;
                chk("fair_rsp0v", bus.Rsp0Valid, 64'(id == 0));
                chk("fair_rsp1v", bus.Rsp1Valid, 64'(id == 1));
                chk("fair_res", bus.RspResult, 64'((c - 2) / 2 + ((id == 1) ? 200 : 100)));
            end
            if (c < 8) begin
                if (c % 2 == 0) n0++;
                else n1++;
            end
            next_cycle();
        end
        idle();

        // single op: Req0 ADD 5+7
        req0(5, 7, 4'b0000);
        #1;
        chk("single_rdy0", bus.Req0Ready, 1);
        chk("single_rdy1", bus.Req1Ready, 0);
        next_cycle();
        idle();
        #1;
        chk("single_alua", bus.AluSrcA, 5);
        chk("single_alub", bus.AluSrcB, 7);
        chk("single_c1_rsp0v", bus.Rsp0Valid, 0);
        chk("single_c1_busy", bus.Busy, 1);
        next_cycle();
        #1;
        chk("single_rsp0v", bus.Rsp0Valid, 1);
        chk("single_rsp1v", bus.Rsp1Valid, 0);
        chk("single_res", bus.RspResult, 12);
        chk("single_zero", bus.RspZero, 0);
        next_cycle();
        #1;
        chk("single_busy_end", bus.Busy, 0);

        // back-pressure on Rsp0 for three cycles
        bus.Rsp0Ready = 1'b0;
        req0(1, 1, 4'b0000);
        #1;
        chk("bp_c0_rdy0", bus.Req0Ready, 1);
        next_cycle();
        req0(3, 4, 4'b0000);
        #1;
        chk("bp_c1_rdy0", bus.Req0Ready, 1);
        next_cycle();
        req0(5, 5, 4'b0000);
        req1(6, 6, 4'b0000);
        for (int c = 2; c < 5; c++) begin
            #1;
            chk("bp_hold_rdy0", bus.Req0Ready, 0);
            chk("bp_hold_rdy1", bus.Req1Ready, 0);
            chk("bp_hold_rsp0v", bus.Rsp0Valid, 1);
            chk("bp_hold_res", bus.RspResult, 2);
            chk("bp_hold_alua", bus.AluSrcA, 3);
            next_cycle();
        end
        bus.Rsp0Ready = 1'b1;
        #1;
        chk("bp_c5_rdy1", bus.Req1Ready, 1);
        chk("bp_c5_rdy0", bus.Req0Ready, 0);
        chk("bp_c5_res", bus.RspResult, 2);
        next_cycle();
        bus.Req1Valid = 1'b0;
        #1;
        chk("bp_c6_rdy0", bus.Req0Ready, 1);
        chk("bp_c6_rsp0v", bus.Rsp0Valid, 1);
        chk("bp_c6_res", bus.RspResult, 7);
        next_cycle();
        idle();
        #1;
        chk("bp_c7_rsp1v", bus.Rsp1Valid, 1);
        chk("bp_c7_res", bus.RspResult, 12);
        next_cycle();
        #1;
        chk("bp_c8_rsp0v", bus.Rsp0Valid, 1);
        chk("bp_c8_res", bus.RspResult, 10);
        next_cycle();
        #1;
        chk("bp_c9_busy", bus.Busy, 0);

        // flush drops the op accepted just before it
        req0(8, 8, 4'b0000);
        #1;
        chk("fl_c0_rdy0", bus.Req0Ready, 1);
        next_cycle();
        bus.Req0Valid = 1'b0;
        bus.Flush     = 1'b1;
        req1(9, 4, 4'b0001);
        #1;
        chk("fl_c1_rdy1", bus.Req1Ready, 0);
        chk("fl_c1_busy", bus.Busy, 1);
        next_cycle();
        bus.Flush = 1'b0;
        #1;
        chk("fl_c2_busy", bus.Busy, 0);
        chk("fl_c2_rsp0v", bus.Rsp0Valid, 0);
        chk("fl_c2_rdy1", bus.Req1Ready, 1);
        next_cycle();
        idle();
        #1;
        chk("fl_c3_rsp0v", bus.Rsp0Valid, 0);
        chk("fl_c3_rsp1v", bus.Rsp1Valid, 0);
        chk("fl_c3_alua", bus.AluSrcA, 9);
        next_cycle();
        #1;
        chk("fl_c4_rsp1v", bus.Rsp1Valid, 1);
        chk("fl_c4_rsp0v", bus.Rsp0Valid, 0);
        chk("fl_c4_res", bus.RspResult, 5);
        next_cycle();
        #1;
        chk("fl_c5_busy", bus.Busy, 0);

        // async reset with both stages occupied
        bus.Rsp0Ready = 1'b0;
        req0(1, 2, 4'b0000);
        #1;
        next_cycle();
        bus.Req0Valid = 1'b0;
        req1(4, 4, 4'b0000);
        #1;
        chk("ar_c1_rdy1", bus.Req1Ready, 1);
        next_cycle();
        bus.Req1Valid = 1'b0;
        #1;
        chk("ar_pre_busy", bus.Busy, 1);
        chk("ar_pre_rsp0v", bus.Rsp0Valid, 1);
        chk("ar_pre_alua", bus.AluSrcA, 4);
        req0(10, 1, 4'b0000);
        req1(20, 2, 4'b0000);
        rst = 1'b1;
        #1;
        chk("ar_busy", bus.Busy, 0);
        chk("ar_rsp0v", bus.Rsp0Valid, 0);
        chk("ar_res", bus.RspResult, 0);
        chk("ar_alua", bus.AluSrcA, 0);
        chk("ar_ctl", bus.AluControl, 0);
        chk("ar_rdy0", bus.Req0Ready, 0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
        bus.Rsp0Ready = 1'b1;
        #1;
        chk("ar_post_rdy0", bus.Req0Ready, 1);
        chk("ar_post_rdy1", bus.Req1Ready, 0);
        next_cycle();
        #1;
        chk("ar_post2_rdy1", bus.Req1Ready, 1);
        chk("ar_post2_rdy0", bus.Req0Ready, 0);
        chk("ar_post2_alua", bus.AluSrcA, 10);
        next_cycle();
        idle();
        repeat (4) next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
